// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES ShiftRows pipeline stage.
// Byte k of a state is held MSB-first: bits [MAX_W-1-8k -: 8] of an MSB-aligned vector.
package aes_pkg;

   localparam int unsigned MAX_NB = 8;
   localparam int unsigned MAX_W  = 32 * MAX_NB;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_e;

   function automatic int unsigned shift_offset(input int unsigned nb, input int unsigned row);
      case (row)
         0:       return 0;
         1:       return 1;
         2:       return (nb == 8) ? 3 : 2;
         default: return (nb == 8) ? 4 : 3;
      endcase
   endfunction

   function automatic int unsigned byte_idx(input int unsigned row, input int unsigned col);
      return 4 * col + row;
   endfunction

   // Columns at or beyond nb are left zero; data and result are MSB-aligned.
   function automatic logic [MAX_W-1:0] shift_rows(input logic [MAX_W-1:0] data,
                                                  input int unsigned   nb,
                                                  input logic          inv);
      logic [MAX_W-1:0] res;
      int unsigned      src;
      res = '0;
      for (int unsigned c = 0; c < MAX_NB; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            if (c < nb) begin
               if (inv)
                  src = (c + nb - shift_offset(nb, r)) % nb;
               else
                  src = (c + shift_offset(nb, r)) % nb;
               res[MAX_W-1-8*byte_idx(r, c) -: 8] = data[MAX_W-1-8*byte_idx(r, src) -: 8];
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/aes_skid_reg.sv
// Two-entry valid/ready skid register; in_ready is taken straight from the state flops.
module aes_skid_reg
   import aes_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   skid_state_e  state_q, state_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         in_fire_c, out_fire_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   assign in_fire_c  = in_valid_i && (state_q != FULL);
   assign out_fire_c = out_ready_i && (state_q != EMPTY);

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (in_fire_c) begin
               state_d = ONE;
               main_d  = in_data_i;
            end
         end
         ONE: begin
            if (in_fire_c && out_fire_c) begin
               main_d = in_data_i;
            end else if (in_fire_c) begin
               state_d = FULL;
               skid_d  = in_data_i;
            end else if (out_fire_c) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_fire_c) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      in_ready_o  = (state_q != FULL);
      out_valid_o = (state_q != EMPTY);
      out_data_o  = main_q;
   end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage for Nb = 4, 6 or 8, with a tag sideband
// and a two-entry skid so the round pipeline can stall without bubbles.
module aes_shift_rows_pipe
   import aes_pkg::*;
#(
   parameter int unsigned NB    = 4,
   parameter int unsigned TAG_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [32*NB-1:0]  in_data,
   input  logic              in_inv,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [32*NB-1:0]  out_data,
   output logic [TAG_W-1:0]  out_tag
);

   localparam int unsigned W  = 32 * NB;
   localparam int unsigned PW = W + TAG_W;

   generate
      if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
         $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
      end
      if (TAG_W < 1) begin : g_bad_tag
         $error("aes_shift_rows_pipe: TAG_W must be at least 1");
      end
   endgenerate

   logic [MAX_W-1:0] in_pad_c;
   logic [MAX_W-1:0] perm_pad_c;
   logic [PW-1:0]    in_pay_c;
   logic [PW-1:0]    out_pay_c;

   // Byte 0 is the MSB, so narrow states are left-aligned into the shared permutation.
   assign in_pad_c   = MAX_W'(in_data) << (MAX_W - W);
   assign perm_pad_c = shift_rows(in_pad_c, NB, in_inv);
   assign in_pay_c   = {W'(perm_pad_c >> (MAX_W - W)), in_tag};

   aes_skid_reg #(
      .W (PW)
   ) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_pay_c),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_pay_c)
   );

   assign out_data = out_pay_c[PW-1 -: W];
   assign out_tag  = out_pay_c[TAG_W-1:0];

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Bench for aes_shift_rows_pipe: directed AES vectors, stalls, reset mid-stall and
// randomized traffic against a byte-matrix reference and a beat queue.
module tb_aes_shift_rows_pipe;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   logic         iv, ir, ov, ordy, inv;
   logic [127:0] id, od;
   logic [3:0]   itag, otag;

   logic         iv8, ir8, ov8, ordy8, inv8;
   logic [255:0] id8, od8;
   logic [3:0]   itag8, otag8;

   typedef struct {
      logic [127:0] d;
      logic [3:0]   t;
   } beat_t;
   beat_t q[$];

   always #5 clk = ~clk;

   aes_shift_rows_pipe #(.NB(4), .TAG_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_data(id), .in_inv(inv),
      .in_tag(itag), .out_valid(ov), .out_ready(ordy), .out_data(od), .out_tag(otag));

   aes_shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_inv(inv8),
      .in_tag(itag8), .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_tag(otag8));

   // Reference: view the state as s[row][col], rotate each row by its offset.
   function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input bit inv_m);
      logic [7:0]   s [4][8];
      logic [7:0]   o [4][8];
      int           off [4];
      int           w;
      int           src;
      logic [255:0] r;
      w = 32 * nb;
      r = '0;
      off[0] = 0;
      off[1] = 1;
      off[2] = (nb == 8) ? 3 : 2;
      off[3] = (nb == 8) ? 4 : 3;
      for (int c = 0; c < nb; c++)
         for (int rr = 0; rr < 4; rr++)
            s[rr][c] = d[w-1-8*(4*c+rr) -: 8];
      for (int c = 0; c < nb; c++)
         for (int rr = 0; rr < 4; rr++) begin
            src = inv_m ? (c - off[rr] + nb) % nb : (c + off[rr]) % nb;
            o[rr][c] = s[rr][src];
         end
      for (int c = 0; c < nb; c++)
         for (int rr = 0; rr < 4; rr++)
            r[w-1-8*(4*c+rr) -: 8] = o[rr][c];
      return r;
   endfunction

   task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // mode 0: 16-beat stream, inv alternating, ready high; mode 1: random valid/ready.
   task automatic run_sb(input int mode, input int ncyc, input int nbeats);
      int  sent;
      int  got;
      bit  fi, fo;
      logic [127:0] exp_d;
      sent = 0;
      got  = 0;
      iv   = 1'b0;
      for (int k = 0; k < ncyc; k++) begin
         chk("sb_out_valid", 256'(ov), 256'(q.size() != 0));
         chk("sb_in_ready", 256'(ir), 256'(q.size() < 2));
         if (ov && q.size() != 0) begin
            chk("sb_data", 256'(od), 256'(q[0].d));
            chk("sb_tag", 256'(otag), 256'(q[0].t));
         end
         if (mode == 0)
            ordy = 1'b1;
         else
            ordy = (k >= ncyc - 12) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
         if (!iv && sent < nbeats && (mode == 0 || (k < ncyc - 12 && $urandom_range(0, 3) != 0))) begin
            iv   = 1'b1;
            id   = rnd128();
            inv  = (mode == 0) ? 1'(sent % 2) : 1'($urandom_range(0, 1));
            itag = 4'(sent);
         end
         fi = iv && ir;
         fo = ov && ordy;
         exp_d = 128'(ref_shift(256'(id), 4, inv));
         cyc();
         if (fo && q.size() != 0) begin
            void'(q.pop_front());
            got++;
         end
         if (fi) begin
            q.push_back('{d: exp_d, t: itag});
            iv = 1'b0;
            sent++;
         end
      end
      chk("sb_beats_out", 256'(got), 256'(nbeats));
   endtask

   logic [127:0] d1, d2, d3;

   initial begin
      iv = 0; ordy = 0; inv = 0; id = '0; itag = '0;
      iv8 = 0; ordy8 = 0; inv8 = 0; id8 = '0; itag8 = '0;
      #1 rst_n = 1'b0;
      #10 rst_n = 1'b1;
      chk("rst_out_valid", 256'(ov), 256'(0));
      chk("rst_in_ready", 256'(ir), 256'(1));
      chk("rst_out_data", 256'(od), 256'(0));
      chk("rst_out_tag", 256'(otag), 256'(0));

      // Forward NB=4 AES vector
      iv = 1; inv = 0; ordy = 1; itag = 4'd3;
      id = 128'hd42711aee0bf98f1b8b45de51e415230;
      cyc();
      chk("fwd4_valid", 256'(ov), 256'(1));
      chk("fwd4_data", 256'(od), 256'(128'hd4bf5d30e0b452aeb84111f11e2798e5));
      chk("fwd4_tag", 256'(otag), 256'(3));

      // Inverse NB=4
      inv = 1; itag = 4'd9;
      id = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
      cyc();
      chk("inv4_data", 256'(od), 256'(128'hd42711aee0bf98f1b8b45de51e415230));
      chk("inv4_tag", 256'(otag), 256'(9));
      iv = 0;
      cyc();
      chk("idle_valid", 256'(ov), 256'(0));

      // Backpressure: tags 1,2,3 offered back-to-back with out_ready low
      d1 = rnd128(); d2 = rnd128(); d3 = rnd128();
      ordy = 0; inv = 0; iv = 1; id = d1; itag = 4'd1;
      cyc();
      chk("bp_ready_after1", 256'(ir), 256'(1));
      id = d2; itag = 4'd2; inv = 1;
      cyc();
      chk("bp_ready_after2", 256'(ir), 256'(0));
      id = d3; itag = 4'd3; inv = 0;
      cyc();
      cyc();
      chk("bp_ready_held", 256'(ir), 256'(0));
      chk("bp_tag_held", 256'(otag), 256'(1));
      chk("bp_data_held", 256'(od), ref_shift(256'(d1), 4, 1'b0));
      ordy = 1;
      cyc();
      chk("bp_rel_tag2", 256'(otag), 256'(2));
      chk("bp_rel_data2", 256'(od), ref_shift(256'(d2), 4, 1'b1));
      cyc();
      iv = 0;
      chk("bp_rel_tag3", 256'(otag), 256'(3));
      chk("bp_rel_data3", 256'(od), ref_shift(256'(d3), 4, 1'b0));
      cyc();
      chk("bp_drained", 256'(ov), 256'(0));

      // NB=8 forward with byte i = i
      for (int i = 0; i < 32; i++) id8[255-8*i -: 8] = 8'(i);
      iv8 = 1; ordy8 = 1; inv8 = 0; itag8 = 4'hA;
      cyc();
      iv8 = 0;
      chk("nb8_col0", 256'(od8[255:224]), 256'(32'h00050e13));
      chk("nb8_col7", 256'(od8[31:0]), 256'(32'h1c010a0f));
      chk("nb8_full", od8, ref_shift(id8, 8, 1'b0));
      chk("nb8_tag", 256'(otag8), 256'(4'hA));
      id8 = {rnd128(), rnd128()}; iv8 = 1; inv8 = 1; itag8 = 4'h5;
      cyc();
      iv8 = 0;
      chk("nb8_inv", od8, ref_shift(id8, 8, 1'b1));

      // Reset mid-stall
      ordy = 0; iv = 1; id = rnd128(); itag = 4'd7;
      cyc();
      id = rnd128(); itag = 4'd8;
      cyc();
      chk("rs_full", 256'(ir), 256'(0));
      iv = 0;
      #3 rst_n = 1'b0;
      #1;
      chk("rs_out_valid", 256'(ov), 256'(0));
      chk("rs_in_ready", 256'(ir), 256'(1));
      chk("rs_out_data", 256'(od), 256'(0));
      #1 rst_n = 1'b1;
      ordy = 1;
      cyc();
      chk("rs_no_stale1", 256'(ov), 256'(0));
      cyc();
      chk("rs_no_stale2", 256'(ov), 256'(0));

      // 16-beat stream, then random traffic
      q.delete();
      run_sb(0, 18, 16);
      q.delete();
      run_sb(1, 400, 120);
      chk("drain_empty", 256'(ov), 256'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
